// File: rtl/conv2d_mc_engine.sv
// Batched multi-output-channel 2D convolution engine over NCHW tensors in external memories.
// One MAC tap per cycle with zero padding, per-channel bias, requantisation shift, ReLU and saturation.
module conv2d_mc_engine #(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic [4:0]            shift_amt,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  sat_flag,
  output logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_en,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  input  logic [DATA_WIDTH-1:0] weight_data,
  output logic                  weight_en,
  output logic [ADDR_WIDTH-1:0] bias_addr,
  input  logic [DATA_WIDTH-1:0] bias_data,
  output logic                  bias_en,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_we,
  output logic                  output_en
);

  localparam int OH = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OW = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int CW = 16;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t ONE     = cnt_t'(1);
  localparam cnt_t B_LAST  = cnt_t'(BATCH_SIZE - 1);
  localparam cnt_t OC_LAST = cnt_t'(OUT_CHANNELS - 1);
  localparam cnt_t IC_LAST = cnt_t'(IN_CHANNELS - 1);
  localparam cnt_t K_LAST  = cnt_t'(KERNEL_SIZE - 1);
  localparam cnt_t OH_LAST = cnt_t'(OH - 1);
  localparam cnt_t OW_LAST = cnt_t'(OW - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

  state_t state, state_nxt;
  cnt_t   b, oc, oy, ox, ic, ky, kx;
  logic signed [ACC_WIDTH-1:0] acc, relu_v, shifted;
  logic        relu_q;
  logic [4:0]  shift_q;
  int          iy, ix;
  logic        in_range, last_tap, last_out, sat_now;
  logic signed [2*DATA_WIDTH-1:0] in_ext, w_ext, prod;
  logic [DATA_WIDTH-1:0] sat_v;

  // Tap geometry and the requantised result of the current accumulator.
  always_comb begin
    iy       = int'(oy) * STRIDE + int'(ky) - PADDING;
    ix       = int'(ox) * STRIDE + int'(kx) - PADDING;
    in_range = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
    in_ext   = (2 * DATA_WIDTH)'($signed(input_data));
    w_ext    = (2 * DATA_WIDTH)'($signed(weight_data));
    prod     = in_ext * w_ext;
    last_tap = (ic == IC_LAST) && (ky == K_LAST) && (kx == K_LAST);
    last_out = (b == B_LAST) && (oc == OC_LAST) && (oy == OH_LAST) && (ox == OW_LAST);
    relu_v   = (relu_q && acc[ACC_WIDTH-1]) ? '0 : acc;
    shifted  = relu_v >>> shift_q;
    sat_now  = 1'b1;
    if (shifted > SAT_MAX) begin
      sat_v = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_v = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_v   = shifted[DATA_WIDTH-1:0];
      sat_now = 1'b0;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    input_en    = 1'b0;
    input_addr  = '0;
    weight_en   = 1'b0;
    weight_addr = '0;
    bias_en     = 1'b0;
    bias_addr   = '0;
    output_en   = 1'b0;
    output_we   = 1'b0;
    output_addr = '0;
    output_data = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_BIAS;
      S_BIAS: begin
        busy      = 1'b1;
        bias_en   = 1'b1;
        bias_addr = ADDR_WIDTH'(oc);
        state_nxt = S_MAC;
      end
      S_MAC: begin
        busy        = 1'b1;
        weight_en   = 1'b1;
        weight_addr = ADDR_WIDTH'(((int'(oc) * IN_CHANNELS + int'(ic)) * KERNEL_SIZE
                                   + int'(ky)) * KERNEL_SIZE + int'(kx));
        // Padding taps leave the input port idle and contribute nothing.
        if (in_range) begin
          input_en   = 1'b1;
          input_addr = ADDR_WIDTH'(((int'(b) * IN_CHANNELS + int'(ic)) * IN_HEIGHT + iy)
                                   * IN_WIDTH + ix);
        end
        if (last_tap) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        output_en   = 1'b1;
        output_we   = 1'b1;
        output_addr = ADDR_WIDTH'(((int'(b) * OUT_CHANNELS + int'(oc)) * OH + int'(oy))
                                  * OW + int'(ox));
        output_data = sat_v;
        state_nxt   = last_out ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign valid = output_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      b        <= '0;
      oc       <= '0;
      oy       <= '0;
      ox       <= '0;
      ic       <= '0;
      ky       <= '0;
      kx       <= '0;
      acc      <= '0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          relu_q   <= relu_en;
          shift_q  <= shift_amt;
          sat_flag <= 1'b0;
          b        <= '0;
          oc       <= '0;
          oy       <= '0;
          ox       <= '0;
          ic       <= '0;
          ky       <= '0;
          kx       <= '0;
        end
        S_BIAS: acc <= ACC_WIDTH'($signed(bias_data));
        S_MAC: begin
          if (in_range) acc <= acc + ACC_WIDTH'(prod);
          if (kx != K_LAST) begin
            kx <= kx + ONE;
          end else begin
            kx <= '0;
            if (ky != K_LAST) begin
              ky <= ky + ONE;
            end else begin
              ky <= '0;
              ic <= (ic == IC_LAST) ? '0 : ic + ONE;
            end
          end
        end
        S_WRITE: begin
          sat_flag <= sat_flag | sat_now;
          if (ox != OW_LAST) begin
            ox <= ox + ONE;
          end else begin
            ox <= '0;
            if (oy != OH_LAST) begin
              oy <= oy + ONE;
            end else begin
              oy <= '0;
              if (oc != OC_LAST) begin
                oc <= oc + ONE;
              end else begin
                oc <= '0;
                b  <= (b == B_LAST) ? '0 : b + ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_mc_engine.sv
// Scoreboard bench for conv2d_mc_engine: a loop-nest reference model queues expected writes,
// a negedge monitor pops and compares them, and per-run checks cover timing and port activity.
module tb_conv2d_mc_engine;

  localparam int B   = 2;
  localparam int IC  = 2;
  localparam int OC  = 2;
  localparam int H   = 6;
  localparam int W   = 6;
  localparam int K   = 3;
  localparam int S   = 2;
  localparam int P   = 1;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int OH  = (H + 2 * P - K) / S + 1;
  localparam int OW  = (W + 2 * P - K) / S + 1;
  localparam int TAPS  = IC * K * K;
  localparam int OUTS  = B * OC * OH * OW;
  localparam int TOTAL = OUTS * (TAPS + 2);
  localparam int IN_N = B * IC * H * W;
  localparam int W_N  = OC * IC * K * K;

  logic clk = 1'b0;
  logic rst, start, relu_en;
  logic [4:0] shift_amt;
  logic busy, done, valid, sat_flag;
  logic [AW-1:0] input_addr, weight_addr, bias_addr, output_addr;
  logic [DW-1:0] input_data, weight_data, bias_data, output_data;
  logic input_en, weight_en, bias_en, output_we, output_en;

  logic signed [DW-1:0] in_mem [IN_N];
  logic signed [DW-1:0] w_mem  [W_N];
  logic signed [DW-1:0] b_mem  [OC];

  typedef struct {int addr; int data;} wr_t;
  wr_t exp_q[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int wr_cnt, first_wr_cyc, last_wr_cyc, ien_cnt, wen_cnt, ben_cnt, addr_viol;
  int exp_ien;
  bit exp_sat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read data is junk whenever the enable is low so stray accumulation is visible.
  assign input_data  = (input_en  && int'(input_addr)  < IN_N) ? in_mem[input_addr]  : 8'h5A;
  assign weight_data = (weight_en && int'(weight_addr) < W_N)  ? w_mem[weight_addr]  : 8'hA5;
  assign bias_data   = (bias_en   && int'(bias_addr)   < OC)   ? b_mem[bias_addr]    : 8'h3C;

  conv2d_mc_engine #(
    .BATCH_SIZE(B), .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .IN_HEIGHT(H), .IN_WIDTH(W),
    .KERNEL_SIZE(K), .STRIDE(S), .PADDING(P), .DATA_WIDTH(DW), .ACC_WIDTH(32), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .shift_amt(shift_amt),
    .busy(busy), .done(done), .valid(valid), .sat_flag(sat_flag),
    .input_addr(input_addr), .input_data(input_data), .input_en(input_en),
    .weight_addr(weight_addr), .weight_data(weight_data), .weight_en(weight_en),
    .bias_addr(bias_addr), .bias_data(bias_data), .bias_en(bias_en),
    .output_addr(output_addr), .output_data(output_data), .output_we(output_we),
    .output_en(output_en)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on every write, plus activity counters for the run checks.
  always @(negedge clk) begin
    if (input_en)  ien_cnt++;
    if (weight_en) wen_cnt++;
    if (bias_en)   ben_cnt++;
    if ((!input_en && input_addr != 0) || (!weight_en && weight_addr != 0) ||
        (!bias_en && bias_addr != 0) || (!output_en && output_addr != 0))
      addr_viol++;
    if (valid === 1'b1) begin
      wr_t e;
      if (wr_cnt == 0) first_wr_cyc = cyc;
      wr_cnt++;
      last_wr_cyc = cyc;
      check("we_en_with_valid", {output_we, output_en}, 2'b11);
      check("queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_addr", output_addr, e.addr);
        check("out_data", $signed(output_data), e.data);
      end
    end
  end

  task automatic fill(input int iv, input int wv, input int b0, input int b1, input bit rnd);
    for (int i = 0; i < IN_N; i++) in_mem[i] = rnd ? DW'($urandom) : DW'(iv);
    for (int i = 0; i < W_N; i++)  w_mem[i]  = rnd ? DW'($urandom) : DW'(wv);
    b_mem[0] = rnd ? DW'($urandom) : DW'(b0);
    b_mem[1] = rnd ? DW'($urandom) : DW'(b1);
  endtask

  // Reference: direct loop nest over the convolution definition.
  task automatic build_model(input bit relu, input int shift);
    exp_q.delete();
    exp_sat = 0;
    exp_ien = 0;
    for (int bb = 0; bb < B; bb++)
      for (int o = 0; o < OC; o++)
        for (int y = 0; y < OH; y++)
          for (int x = 0; x < OW; x++) begin
            longint acc = longint'(b_mem[o]);
            longint r;
            for (int c = 0; c < IC; c++)
              for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                  int iy = y * S + ky - P;
                  int ix = x * S + kx - P;
                  if (iy >= 0 && iy < H && ix >= 0 && ix < W) begin
                    acc += longint'(in_mem[((bb * IC + c) * H + iy) * W + ix]) *
                           longint'(w_mem[((o * IC + c) * K + ky) * K + kx]);
                    exp_ien++;
                  end
                end
            r = (relu && acc < 0) ? 0 : acc;
            r = r >>> shift;
            if (r > 127) begin r = 127; exp_sat = 1; end
            else if (r < -128) begin r = -128; exp_sat = 1; end
            exp_q.push_back('{((bb * OC + o) * OH + y) * OW + x, int'(r)});
          end
  endtask

  task automatic run(input bit relu, input int shift, input int repulse_at, input bit start_in_done);
    int cnt = 0, guard = 0, done_cyc = 0, c0;
    bit seen_done = 0;
    build_model(relu, shift);
    wr_cnt = 0; ien_cnt = 0; wen_cnt = 0; ben_cnt = 0; addr_viol = 0;
    @(negedge clk);
    relu_en = relu;
    shift_amt = 5'(shift);
    start = 1'b1;
    c0 = cyc;
    while (!seen_done && guard < 4 * TOTAL) begin
      @(negedge clk);
      guard++;
      if (busy) cnt++;
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
        start = start_in_done;
      end else begin
        start = busy && (cnt == repulse_at);
      end
    end
    check("done_seen", seen_done, 1);
    check("busy_cycles", cnt, TOTAL);
    check("first_write_latency", first_wr_cyc - c0, TAPS + 2);
    check("done_after_last_write", done_cyc - last_wr_cyc, 1);
    check("write_count", wr_cnt, OUTS);
    check("queue_drained", exp_q.size(), 0);
    check("sat_flag", sat_flag, exp_sat);
    check("input_en_taps", ien_cnt, exp_ien);
    check("weight_en_taps", wen_cnt, OUTS * TAPS);
    check("bias_reads", ben_cnt, OUTS);
    check("addr_zero_when_disabled", addr_viol, 0);
    @(negedge clk);
    start = 1'b0;
    check("done_one_pulse", done, 0);
    repeat (2) @(negedge clk);
    check("idle_after_done", busy, 0);
    check("sat_flag_holds", sat_flag, exp_sat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; shift_amt = '0;
    wr_cnt = 0; ien_cnt = 0; wen_cnt = 0; ben_cnt = 0; addr_viol = 0;
    fill(1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_enables", {input_en, weight_en, bias_en, output_en, output_we}, 0);
    check("rst_addrs", {input_addr, weight_addr, bias_addr, output_addr, output_data}, 0);
    rst = 1'b0;

    // All ones: padding gives corner/edge/interior sums.
    run(0, 0, -1, 0);

    // Random tensors with random ReLU/shift, including ignored start pulses.
    for (int i = 0; i < 4; i++) begin
      fill(0, 0, 0, 0, 1);
      run(1'($urandom_range(0, 1)), $urandom_range(0, 9), (i == 1) ? 20 : -1, i == 2);
    end

    // Saturation, ReLU clamp, and floor shift on positive/negative bias-only accumulators.
    fill(127, 127, 0, 0, 0);
    run(0, 0, -1, 0);
    fill(5, -1, 0, 0, 0);
    run(1, 0, -1, 0);
    fill(0, 3, 100, -7, 0);
    run(0, 2, -1, 0);
    run(0, 1, -1, 0);

    // Reset mid-run aborts immediately; a following start runs normally.
    begin
      int cnt = 0, guard = 0, wr_before;
      fill(0, 0, 0, 0, 1);
      build_model(0, 3);
      @(negedge clk);
      relu_en = 1'b0; shift_amt = 5'd3; start = 1'b1;
      while (cnt < 50 && guard < 200) begin
        @(negedge clk);
        start = 1'b0;
        guard++;
        if (busy) cnt++;
      end
      check("abort_reached_cycle_50", cnt, 50);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_enables", {input_en, weight_en, bias_en, output_en, output_we, valid}, 0);
      check("abort_addrs", {input_addr, weight_addr, bias_addr, output_addr}, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      wr_before = wr_cnt;
      repeat (TOTAL) @(negedge clk);
      check("no_write_after_abort", wr_cnt - wr_before, 0);
      check("idle_after_abort", busy, 0);
    end
    run(0, 3, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv2d_mc_engine.md
Name: conv2d_mc_engine

Overview:
- Parametrised successor to the single-output-channel conv2d engine.
- Computes a batched, multi-output-channel 2D convolution over NCHW tensors held in external memories.
- Adds zero padding, per-output-channel bias, run-time requantisation shift, optional ReLU and signed saturation.
- Sits between the input, weight, bias and output memory banks and is sequenced by a start/done handshake from the layer controller.

Parameters:
- BATCH_SIZE, 1, batch count
- IN_CHANNELS, 2, input channels
- OUT_CHANNELS, 2, output channels
- IN_HEIGHT, 8, input rows
- IN_WIDTH, 8, input columns
- KERNEL_SIZE, 2, square kernel edge K
- STRIDE, 2, stride in both dimensions
- PADDING, 0, zero-pad rows/columns on each side
- DATA_WIDTH, 8, signed two's-complement width of input, weight, bias and output
- ACC_WIDTH, 32, signed accumulator width
- ADDR_WIDTH, 16, width of every memory address port

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle request to run a layer
- relu_en, in, 1, clamp negative results to 0; sampled at start
- shift_amt, in, 5, arithmetic right shift before saturation; sampled at start
- busy, out, 1, high from the cycle after start until done
- done, out, 1, one-cycle pulse at completion
- valid, out, 1, equals output_we
- sat_flag, out, 1, sticky: any output saturated in this run
- input_addr, out, ADDR_WIDTH, input read address
- input_data, in, DATA_WIDTH, combinational read data
- input_en, out, 1, input read enable
- weight_addr, out, ADDR_WIDTH, weight read address
- weight_data, in, DATA_WIDTH, combinational read data
- weight_en, out, 1, weight read enable
- bias_addr, out, ADDR_WIDTH, bias read address
- bias_data, in, DATA_WIDTH, combinational read data
- bias_en, out, 1, bias read enable
- output_addr, out, ADDR_WIDTH, output write address
- output_data, out, DATA_WIDTH, write data
- output_we, out, 1, write strobe
- output_en, out, 1, output port enable

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-run aborts at once, with no further memory activity. start after release runs normally.
- Derived sizes: OH = (IN_HEIGHT + 2P - K)/S + 1; OW likewise.
- Address maps:
  - input: ((b*IC+c)*IN_HEIGHT+y)*IN_WIDTH+x
  - weight: ((oc*IC+ic)*K+ky)*K+kx
  - bias: oc
  - output: ((b*OC+oc)*OH+oy)*OW+ox
- Memories are read combinationally: data is valid in the same cycle as addr/en.
- Loop order, outer to inner: b, oc, oy, ox, then ic, ky, kx.
- FSM states:
  - IDLE: start=1 latches relu_en/shift_amt, clears sat_flag, resets all counters, goes to BIAS.
  - BIAS: bias_en=1; acc <= sign-extended bias_data; go to MAC.
  - MAC: one tap per cycle.
    - Tap coordinates: iy = oy*S+ky-P, ix = ox*S+kx-P.
    - In range: input_en=weight_en=1; acc += input_data*weight_data (signed, full-precision product, sign-extended).
    - Out of range (padding): input_en=0, input_addr=0, weight_en=1, contribution 0.
    - After IC*K*K taps, go to WRITE.
  - WRITE: output_en=output_we=valid=1.
    - output_data = sat(r), where r = relu ? max(acc,0) : acc, then r >>>= shift.
    - Shift is arithmetic (floor).
    - sat() clamps to [-2^(DW-1), 2^(DW-1)-1]; any clamp sets sat_flag.
    - On the last output go to DONE, otherwise advance ox/oy/oc/b and go to BIAS.
  - DONE: done=1 for one cycle, busy=0, return to IDLE. sat_flag holds until the next start.
- busy: 1 in BIAS/MAC/WRITE.
- start while busy or in DONE is ignored.
- Enables are 0 in every state except the one that uses them. Addresses are 0 when their enable is low.
- Latency: start to first write = 1+IC*K*K+1 cycles. Total busy cycles = B*OC*OH*OW*(IC*K*K+2). done follows the last write by 1 cycle.
- The accumulator never wraps within ACC_WIDTH for default parameters.

Test Plan:
- Defaults with OC=1; inputs all 1, weights all 1, bias 0, shift 0 -> 16 writes of 8, addresses 0..15, busy exactly 160 cycles, done one cycle later, sat_flag=0.
- IC=1, OC=1, 4x4, K=3, S=1, P=1; all ones -> 4x4 output with corners 4, edges 6, interior 9. input_en is never high for out-of-range taps.
- Defaults, OC=2; weights oc0 = 1, oc1 = -1, bias {3,-2}, inputs 2 -> oc0 outputs 19 at addresses 0..15, oc1 outputs -18 (0xEE) at addresses 16..31.
- Saturation/ReLU/shift:
  - inputs 127, weights 127 -> all 127, sat_flag=1.
  - weights -1, relu_en=1 -> all 0.
  - acc 100 with shift 2 -> 25.
  - acc -7 with shift 1 -> -4.
- rst pulsed for 1 cycle at busy cycle 50 -> outputs go to 0 asynchronously and no writes occur afterwards. A new start gives the full, correct 160-cycle run.
- start re-pulsed at busy cycle 20 -> ignored: write count, addresses and cycle count are identical to the undisturbed run.
